// File: rtl/h264_bs_axi_writer_if.sv
// AXI3 write-only channel bundle between the bitstream writer (master) and
// the memory interconnect (slave).
interface h264_bs_axi_writer_if #(
  parameter int AXI_AW   = 32,
  parameter int AXI_SIDW = 6,
  parameter int AXI_DW   = 64
);
  logic [AXI_SIDW-1:0] awid;
  logic [AXI_AW-1:0]   awaddr;
  logic [3:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [1:0]          awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;

  logic [AXI_SIDW-1:0] wid;
  logic [AXI_DW-1:0]   wdata;
  logic [AXI_DW/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [AXI_SIDW-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/h264_bs_axi_writer.sv
// Packs the encoder byte stream into 64-bit words, buffers them and writes
// them to a DDR ring buffer with 16-beat AXI3 INCR bursts plus a flush drain.
module h264_bs_axi_writer #(
  parameter int AXI_DW     = 64,
  parameter int AXI_AW     = 32,
  parameter int AXI_SIDW   = 6,
  parameter int AXI_WID    = 0,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  axi_clk,
  input  logic                  axi_rstn,
  input  logic                  start,
  input  logic [AXI_AW-1:0]     cfg_base_addr,
  input  logic [AXI_AW-1:0]     cfg_size,
  input  logic                  flush,
  input  logic                  winc,
  input  logic [7:0]            wdata,
  output logic [31:0]           byte_count,
  output logic                  done,
  output logic                  err_ovf,
  output logic                  err_bresp,
  h264_bs_axi_writer_if.master  axi_m
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int BURST = 16;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  state_t state, state_nxt;

  logic [AXI_DW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_idx;
  logic [PW:0]       fifo_cnt;
  logic              fifo_full, fifo_empty, push, pop;

  logic [AXI_DW-1:0] pack_word, lane_word, push_word;
  logic [2:0]        pcnt;
  logic              flush_pending, accept, full_push, part_push;

  logic [AXI_AW-1:0] base_q, size_q, wr_ptr, ptr_sum;
  logic [4:0]        len;
  logic [3:0]        beat;
  logic              start_ok, go_full, go_short, launch, done_cond, last_beat;
  logic              unused_bid;

  assign fifo_full  = fifo_cnt == (PW+1)'(FIFO_DEPTH);
  assign fifo_empty = fifo_cnt == '0;
  assign start_ok   = start && state == IDLE && fifo_empty;

  // A flush pending or a full FIFO drops the byte outright, so a full FIFO
  // never leaves stray bytes stuck in the packer.
  assign accept    = winc && !flush_pending && !fifo_full;
  assign lane_word = AXI_DW'(wdata) << {pcnt, 3'b000};
  assign full_push = accept && pcnt == 3'd7;
  assign part_push = flush_pending && pcnt != 3'd0 && !fifo_full;
  assign push      = full_push || part_push;
  assign push_word = accept ? (pack_word | lane_word) : pack_word;

  assign go_full   = fifo_cnt >= (PW+1)'(BURST);
  assign go_short  = flush_pending && pcnt == 3'd0 && !fifo_empty;
  assign last_beat = beat == 4'(len - 5'd1);
  assign pop       = state == DATA && !fifo_empty && axi_m.wready;
  assign ptr_sum   = wr_ptr + AXI_AW'({len, 3'b000});

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!axi_rstn) begin
      pcnt          <= '0;
      pack_word     <= '0;
      byte_count    <= '0;
      err_ovf       <= 1'b0;
      flush_pending <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= done_cond;
      if (start_ok) begin
        pcnt       <= '0;
        pack_word  <= '0;
        byte_count <= '0;
        err_ovf    <= 1'b0;
      end else begin
        if (accept) begin
          pcnt       <= pcnt + 3'd1;
          byte_count <= byte_count + 32'd1;
          pack_word  <= full_push ? '0 : (pack_word | lane_word);
        end else if (part_push) begin
          pcnt      <= '0;
          pack_word <= '0;
        end
        if (winc && !accept) err_ovf <= 1'b1;
      end
      if (done_cond)  flush_pending <= 1'b0;
      else if (flush) flush_pending <= 1'b1;
    end
  end

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      rd_ptr   <= '0;
      wr_idx   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_idx <= wr_idx + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // NOTE: the storage array has no reset; clearing the pointers and count
  // empties the FIFO, and leaving the array unreset lets it map to RAM.
  always_ff @(posedge axi_clk) begin
    if (push) mem[wr_idx] <= push_word;
  end

  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state     <= IDLE;
      base_q    <= '0;
      size_q    <= '0;
      wr_ptr    <= '0;
      len       <= '0;
      beat      <= '0;
      err_bresp <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        base_q    <= cfg_base_addr & ~AXI_AW'(127);
        size_q    <= cfg_size;
        wr_ptr    <= '0;
        err_bresp <= 1'b0;
      end
      if (launch) begin
        len  <= go_full ? 5'(BURST) : 5'(fifo_cnt);
        beat <= '0;
      end else if (pop) begin
        beat <= beat + 4'd1;
      end
      if (state == RESP && axi_m.bvalid) begin
        wr_ptr <= (ptr_sum >= size_q) ? ptr_sum - size_q : ptr_sum;
        if (axi_m.bresp != 2'b00) err_bresp <= 1'b1;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt     = state;
    launch        = 1'b0;
    done_cond     = 1'b0;
    axi_m.awvalid = 1'b0;
    axi_m.wvalid  = 1'b0;
    axi_m.wlast   = 1'b0;
    axi_m.bready  = 1'b0;
    unique case (state)
      IDLE: begin
        if (go_full || go_short) begin
          launch    = 1'b1;
          state_nxt = ADDR;
        end else if (flush_pending && pcnt == 3'd0) begin
          done_cond = 1'b1;
        end
      end
      ADDR: begin
        axi_m.awvalid = 1'b1;
        if (axi_m.awready) state_nxt = DATA;
      end
      DATA: begin
        axi_m.wvalid = !fifo_empty;
        axi_m.wlast  = last_beat;
        if (pop && last_beat) state_nxt = RESP;
      end
      RESP: begin
        axi_m.bready = 1'b1;
        if (axi_m.bvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign axi_m.awid    = AXI_SIDW'(AXI_WID);
  assign axi_m.awaddr  = base_q + wr_ptr;
  assign axi_m.awlen   = 4'(len - 5'd1);
  assign axi_m.awsize  = 3'd3;
  assign axi_m.awburst = 2'd1;
  assign axi_m.awlock  = 2'd0;
  assign axi_m.awcache = 4'b0011;
  assign axi_m.awprot  = 3'd0;
  assign axi_m.wid     = AXI_SIDW'(AXI_WID);
  assign axi_m.wdata   = mem[rd_ptr];
  assign axi_m.wstrb   = '1;
  assign unused_bid    = ^axi_m.bid;

endmodule
